// File: rtl/sisc_pkg.sv
// SISC fetch queue shared definitions.
// Widths and fetch FSM encoding used across the fetch path.
package sisc_pkg;

  localparam int SISC_ADDR_W = 16;
  localparam int SISC_DATA_W = 32;

  typedef enum logic [1:0] {
    FQ_IDLE  = 2'b00,
    FQ_REQ   = 2'b01,
    FQ_DRAIN = 2'b10
  } fq_state_e;

endpackage

// File: rtl/sisc_sync_fifo.sv
// Synchronous FIFO with clear; head word is combinational.
// Storage, pointers and occupancy for the prefetch queue.
module sisc_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 48,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Stale words past rd_ptr are masked so an empty queue reads 0.
  assign empty = (cnt == '0);
  assign head  = empty ? '0 : mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/sisc_fetch_queue.sv
// SISC instruction prefetch queue: sequential fetch ahead
// of the IR, one outstanding request, flush/redirect.
module sisc_fetch_queue
  import sisc_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = SISC_ADDR_W,
  parameter  int DATA_W = SISC_DATA_W,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [DATA_W-1:0] im_data,
  input  logic              ir_load,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [CW-1:0]     q_count
);

  fq_state_e state;
  fq_state_e state_nx;

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        drain_addr;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            cnt_after;
  logic                     empty;
  logic                     push;
  logic                     pop;

  assign push      = (state == FQ_REQ) & im_ack & ~flush;
  assign pop       = ir_load & ~empty & ~flush;
  assign cnt_after = cnt + CW'(1) - CW'(pop);

  always_comb begin
    state_nx = FQ_IDLE;
    im_req   = 1'b0;
    unique case (state)
      FQ_IDLE: begin
        if (!flush && cnt < CW'(DEPTH))
          state_nx = FQ_REQ;
      end
      FQ_REQ: begin
        im_req = 1'b1;
        // A flush that races the ack has nothing left in flight.
        if (flush)
          state_nx = im_ack ? FQ_IDLE : FQ_DRAIN;
        else if (im_ack)
          state_nx = (cnt_after < CW'(DEPTH)) ? FQ_REQ : FQ_IDLE;
        else
          state_nx = FQ_REQ;
      end
      FQ_DRAIN: begin
        im_req   = 1'b1;
        state_nx = im_ack ? FQ_IDLE : FQ_DRAIN;
      end
      default: state_nx = FQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state      <= FQ_IDLE;
      fetch_pc   <= '0;
      drain_addr <= '0;
    end else begin
      state <= state_nx;
      if (flush)
        fetch_pc <= flush_addr;
      else if (push)
        fetch_pc <= fetch_pc + ADDR_W'(1);
      if (flush && state == FQ_REQ)
        drain_addr <= fetch_pc;
    end
  end

  assign im_addr = (state == FQ_DRAIN) ? drain_addr : fetch_pc;

  sisc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_f (rst_f),
    .push  (push),
    .pop   (pop),
    .clr   (flush),
    .wdata ({fetch_pc, im_data}),
    .head  (head),
    .empty (empty),
    .count (cnt)
  );

  assign instr_valid         = ~empty;
  assign {instr_pc, instr}   = head;
  assign q_count             = cnt;

endmodule

// File: tb/tb_sisc_fetch_queue.sv
// Bench for sisc_fetch_queue: directed vector table,
// corner sequences and random traffic vs a queue model.
module tb_sisc_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_f = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_addr = '0;
  logic          im_ack = 1'b0;
  logic [DW-1:0] im_data = '0;
  logic          ir_load = 1'b0;
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [CW-1:0] q_count;

  int vectors = 0;
  int miscompares = 0;

  sisc_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_data     (im_data),
    .ir_load     (ir_load),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .q_count     (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Reference model: list of {pc,data}, plus whether a live
  // fetch or an abandoned one is outstanding.
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            m_fetch;
  bit            m_drain;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_daddr;

  task automatic m_reset();
    mq.delete();
    m_fetch = 0;
    m_drain = 0;
    m_pc    = '0;
    m_daddr = '0;
  endtask

  task automatic m_check();
    bit            req;
    int            n;
    n   = mq.size();
    req = m_fetch || m_drain;
    chk("im_req", im_req, req);
    if (req)
      chk("im_addr", im_addr, m_drain ? m_daddr : m_pc);
    chk("instr_valid", instr_valid, n > 0);
    chk("instr", instr, n > 0 ? mq[0].d : '0);
    chk("instr_pc", instr_pc, n > 0 ? mq[0].pc : '0);
    chk("q_count", q_count, n);
  endtask

  task automatic m_step();
    bit ack;
    bit pop;
    int n;
    ack = im_ack && (m_fetch || m_drain);
    n   = mq.size();
    if (flush) begin
      mq.delete();
      if (m_fetch && !ack) begin
        m_drain = 1;
        m_daddr = m_pc;
      end else if (m_drain && ack) begin
        m_drain = 0;
      end
      m_fetch = 0;
      m_pc    = flush_addr;
    end else begin
      pop = ir_load && n > 0;
      if (pop)
        void'(mq.pop_front());
      if (m_drain) begin
        if (ack) m_drain = 0;
      end else if (m_fetch) begin
        if (ack) begin
          mq.push_back('{m_pc, im_data});
          m_pc = m_pc + 1'b1;
          if (mq.size() >= DEPTH) m_fetch = 0;
        end
      end else if (n < DEPTH) begin
        m_fetch = 1;
      end
    end
  endtask

  task automatic edge_();
    m_check();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    edge_();
  endtask

  typedef struct {
    logic          fl;
    logic [AW-1:0] fa;
    logic          ack;
    logic [DW-1:0] d;
    logic          ld;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_cnt;
    logic          e_val;
    logic [AW-1:0] e_pc;
    logic [DW-1:0] e_ins;
  } vec_t;

  vec_t tv[$];

  initial begin
    // fl fa ack d ld | req addr cnt val pc instr
    tv.push_back('{0,0,1,0,0,            0,0,0,0,0,0});
    tv.push_back('{0,0,1,32'hA0000000,0, 1,0,0,0,0,0});
    tv.push_back('{0,0,1,32'hA0000001,0, 1,1,1,1,0,32'hA0000000});
    tv.push_back('{0,0,1,32'hA0000002,0, 1,2,2,1,0,32'hA0000000});
    tv.push_back('{0,0,1,32'hA0000003,0, 1,3,3,1,0,32'hA0000000});
    tv.push_back('{0,0,0,0,0,            0,0,4,1,0,32'hA0000000});
    tv.push_back('{0,0,0,0,1,            0,0,4,1,0,32'hA0000000});
    tv.push_back('{0,0,0,0,0,            0,0,3,1,1,32'hA0000001});
    tv.push_back('{0,0,1,32'hA0000004,0, 1,4,3,1,1,32'hA0000001});
    tv.push_back('{0,0,0,0,1,            0,0,4,1,1,32'hA0000001});
    tv.push_back('{0,0,0,0,0,            0,0,3,1,2,32'hA0000002});
    tv.push_back('{1,16'h0040,0,0,0,     1,5,3,1,2,32'hA0000002});
    tv.push_back('{0,0,1,32'hDEADBEEF,0, 1,5,0,0,0,0});
    tv.push_back('{0,0,0,0,0,            0,0,0,0,0,0});
    tv.push_back('{0,0,1,32'hA0000040,0, 1,16'h0040,0,0,0,0});
    tv.push_back('{0,0,0,0,0,            1,16'h0041,1,1,16'h0040,
                   32'hA0000040});

    // Reset, then abort a pending REQ with a second reset.
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_f = 1'b1;
    cycle();
    cycle();
    #2;
    rst_f  = 1'b0;
    im_ack = 1'b1;
    #1;
    chk("rst_im_req", im_req, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_count", q_count, 0);
    m_reset();
    @(posedge clk);
    #1 rst_f = 1'b1;

    // Streaming, full/pop, flush during wait.
    for (int i = 0; i < tv.size(); i++) begin
      flush      = tv[i].fl;
      flush_addr = tv[i].fa;
      im_ack     = tv[i].ack;
      im_data    = tv[i].d;
      ir_load    = tv[i].ld;
      @(negedge clk);
      chk($sformatf("tv%0d_req", i), im_req, tv[i].e_req);
      if (tv[i].e_req)
        chk($sformatf("tv%0d_addr", i), im_addr, tv[i].e_addr);
      chk($sformatf("tv%0d_cnt", i), q_count, tv[i].e_cnt);
      chk($sformatf("tv%0d_val", i), instr_valid, tv[i].e_val);
      chk($sformatf("tv%0d_pc", i), instr_pc, tv[i].e_pc);
      chk($sformatf("tv%0d_ins", i), instr, tv[i].e_ins);
      edge_();
    end

    // Address wrap and pop on empty.
    flush = 1; flush_addr = 16'hFFFF; im_ack = 0; ir_load = 0;
    cycle();
    flush = 0; im_ack = 1;
    cycle();
    im_ack = 0;
    cycle();
    im_ack = 1; im_data = 32'h1111;
    @(negedge clk);
    chk("wrap_addr0", im_addr, 16'hFFFF);
    edge_();
    im_data = 32'h2222;
    @(negedge clk);
    chk("wrap_addr1", im_addr, 16'h0000);
    edge_();
    im_ack = 0; ir_load = 1;
    @(negedge clk);
    chk("wrap_pc0", instr_pc, 16'hFFFF);
    chk("wrap_cnt", q_count, 2);
    edge_();
    @(negedge clk);
    chk("wrap_pc1", instr_pc, 16'h0000);
    edge_();
    repeat (2) begin
      @(negedge clk);
      chk("empty_cnt", q_count, 0);
      chk("empty_val", instr_valid, 0);
      edge_();
    end
    ir_load = 0;

    // Push and pop together at count 3, then with flush.
    im_ack = 1;
    repeat (3) begin
      im_data = $urandom;
      cycle();
    end
    ir_load = 1;
    @(negedge clk);
    chk("sim_cnt_pre", q_count, 3);
    edge_();
    @(negedge clk);
    chk("sim_cnt", q_count, 3);
    chk("sim_req", im_req, 1);
    flush = 1; flush_addr = 16'h0100;
    edge_();
    @(negedge clk);
    chk("fl_cnt", q_count, 0);
    chk("fl_req", im_req, 0);
    flush = 0; im_ack = 0; ir_load = 0;
    edge_();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      flush      = ($urandom_range(0, 15) == 0);
      flush_addr = AW'($urandom);
      im_ack     = ($urandom_range(0, 3) != 0);
      im_data    = $urandom;
      ir_load    = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
